// File: rtl/aud_pkg.sv
// Shared constants, FSM encoding and the saturation helper for the
// audio compensating FIR decimator.
package aud_pkg;

  localparam int NTAPS_DEF     = 32;
  localparam int COEF_BITS_DEF = 16;
  localparam int ACC_WIDTH_DEF = 40;
  localparam int COEF_FRAC     = 15;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_MAC   = 2'd2,
    ST_ROUND = 2'd3
  } fir_state_e;

  // Clip v to the signed range of a 'bits'-wide word.
  function automatic longint sat_clip(input longint v, input int bits);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (bits - 1)) - longint'(1);
    lo = -hi - longint'(1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/aud_fir_coef_rom.sv
// Coefficient table for the compensating FIR, synchronous read.
// The one-cycle latency lines the coefficient up with the buffer read.
// Only the first half is stored; the filter is symmetric, so index k and
// NTAPS-1-k share an entry (bitwise inverse of k for a power-of-two NTAPS).
module aud_fir_coef_rom
  import aud_pkg::*;
#(
  parameter int NTAPS     = NTAPS_DEF,
  parameter int COEF_BITS = COEF_BITS_DEF
) (
  input  logic                         CLK,
  input  logic                         RSTb,
  input  logic [$clog2(NTAPS)-1:0]     k_i,
  output logic signed [COEF_BITS-1:0]  coef_o
);
  localparam int AW = $clog2(NTAPS);

  logic [AW-1:0] mirror;
  int            coef_val;
  int            mirror_idx;

  // Fold the tap index onto the stored half and look up the value.
  always_comb begin
    mirror     = k_i[AW-1] ? ~k_i : k_i;
    mirror_idx = int'(mirror);
    coef_val   = 0;
    case (mirror_idx)
      0:       coef_val = -20;
      1:       coef_val = -40;
      2:       coef_val = 30;
      3:       coef_val = 80;
      4:       coef_val = -50;
      5:       coef_val = -150;
      6:       coef_val = 70;
      7:       coef_val = 280;
      8:       coef_val = -90;
      9:       coef_val = -480;
      10:      coef_val = 100;
      11:      coef_val = 850;
      12:      coef_val = -110;
      13:      coef_val = -1650;
      14:      coef_val = 120;
      15:      coef_val = 17444;
      default: coef_val = 0;
    endcase
  end

  // Registered read port.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) coef_o <= '0;
    else       coef_o <= COEF_BITS'(coef_val);
  end

endmodule

// File: rtl/aud_fir_decim.sv
// Droop-compensating FIR decimator placed behind the audio CIC.
// One multiply-accumulate per cycle over a circular sample buffer; every
// DECIM-th input sample starts a computation whose rounded, saturated
// result appears on x_out with a one-cycle out_tick.
//
// state | meaning
// CLEAR | zero the sample buffer, one entry per cycle; inputs ignored
// IDLE  | waiting for a trigger (input sample at the last phase)
// MAC   | issue NTAPS reads, then let the read/product pipeline drain
// ROUND | round, saturate and publish x_out with out_tick
module aud_fir_decim
  import aud_pkg::*;
#(
  parameter int BITS      = 16,
  parameter int NTAPS     = NTAPS_DEF,
  parameter int DECIM     = 2,
  parameter int COEF_BITS = COEF_BITS_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                   CLK,
  input  logic                   RSTb,
  input  logic                   in_tick,
  input  logic signed [BITS-1:0] x_in,
  output logic signed [BITS-1:0] x_out,
  output logic                   out_tick,
  output logic                   busy,
  output logic                   overrun
);
  localparam int AW    = $clog2(NTAPS);
  localparam int PW    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int CW    = $clog2(NTAPS + 2) + 1;
  localparam int PRODW = BITS + COEF_BITS;
  localparam logic signed [ACC_WIDTH-1:0] RND_HALF = ACC_WIDTH'(1) <<< (COEF_FRAC - 1);

  fir_state_e                  state_q;
  logic [AW-1:0]               wp_q;
  logic [AW-1:0]               base_q;
  logic [PW-1:0]               phase_q;
  logic [CW-1:0]               cnt_q;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [PRODW-1:0]     prod_q;
  logic                        rd_vld_q;
  logic                        prod_vld_q;
  logic signed [BITS-1:0]      x_out_q;
  logic                        out_tick_q;
  logic                        busy_q;
  logic                        overrun_q;

  logic signed [BITS-1:0]      mem [NTAPS];
  logic signed [BITS-1:0]      rd_q;
  logic signed [COEF_BITS-1:0] coef_q;

  logic                        trig_d;
  logic                        rd_en_d;
  logic [AW-1:0]               k_d;
  logic [AW-1:0]               rd_addr_d;
  logic                        mem_we_d;
  logic [AW-1:0]               mem_wa_d;
  logic signed [BITS-1:0]      mem_wd_d;
  logic signed [PRODW-1:0]     prod_d;
  logic signed [ACC_WIDTH-1:0] rnd_d;
  logic signed [BITS-1:0]      x_out_d;

  // Trigger decode, tap index and read address derived from the MAC down-counter.
  always_comb begin
    trig_d    = in_tick && (state_q != ST_CLEAR) && (phase_q == PW'(DECIM - 1));
    rd_en_d   = (state_q == ST_MAC) && (cnt_q >= CW'(2));
    k_d       = AW'(CW'(NTAPS + 1) - cnt_q);
    rd_addr_d = base_q - AW'(1) - k_d;
  end

  // Single buffer write port: zero fill while clearing, else the new sample.
  always_comb begin
    mem_we_d = 1'b0;
    mem_wa_d = wp_q;
    mem_wd_d = x_in;
    if (state_q == ST_CLEAR) begin
      mem_we_d = 1'b1;
      mem_wa_d = cnt_q[AW-1:0];
      mem_wd_d = '0;
    end else if (in_tick) begin
      mem_we_d = 1'b1;
    end
  end

  // Datapath arithmetic: full-precision product, round-half-up, saturate.
  always_comb begin
    prod_d  = PRODW'(rd_q) * PRODW'(coef_q);
    rnd_d   = (acc_q + RND_HALF) >>> COEF_FRAC;
    x_out_d = BITS'(sat_clip(longint'(rnd_d), BITS));
  end

  // Sample buffer storage with a registered read (no reset; CLEAR zeroes it).
  always_ff @(posedge CLK) begin
    if (mem_we_d) mem[mem_wa_d] <= mem_wd_d;
    rd_q <= mem[rd_addr_d];
  end

  aud_fir_coef_rom #(
    .NTAPS     (NTAPS),
    .COEF_BITS (COEF_BITS)
  ) u_coef_rom (
    .CLK    (CLK),
    .RSTb   (RSTb),
    .k_i    (k_d),
    .coef_o (coef_q)
  );

  // Controller FSM, sample pointers, MAC pipeline and registered outputs.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= CW'(NTAPS - 1);
      wp_q       <= '0;
      base_q     <= '0;
      phase_q    <= '0;
      acc_q      <= '0;
      prod_q     <= '0;
      rd_vld_q   <= 1'b0;
      prod_vld_q <= 1'b0;
      x_out_q    <= '0;
      out_tick_q <= 1'b0;
      busy_q     <= 1'b1;
      overrun_q  <= 1'b0;
    end else begin
      out_tick_q <= 1'b0;
      rd_vld_q   <= rd_en_d;
      prod_vld_q <= rd_vld_q;
      prod_q     <= prod_d;
      if (prod_vld_q) acc_q <= acc_q + ACC_WIDTH'(prod_q);

      if (in_tick && (state_q != ST_CLEAR)) begin
        wp_q    <= wp_q + AW'(1);
        phase_q <= (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
      end

      case (state_q)
        ST_CLEAR: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_IDLE: begin
          if (trig_d) begin
            state_q <= ST_MAC;
            busy_q  <= 1'b1;
            base_q  <= wp_q + AW'(1);
            acc_q   <= '0;
            cnt_q   <= CW'(NTAPS + 1);
          end
        end
        ST_MAC: begin
          // Reads use the latched base, so a late trigger cannot disturb them.
          if (trig_d) overrun_q <= 1'b1;
          if (cnt_q == '0) state_q <= ST_ROUND;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        ST_ROUND: begin
          if (trig_d) overrun_q <= 1'b1;
          x_out_q    <= x_out_d;
          out_tick_q <= 1'b1;
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  assign x_out    = x_out_q;
  assign out_tick = out_tick_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_aud_fir_decim.sv
// Bench for aud_fir_decim: an arithmetic FIR model over a sample history,
// a scoreboard of expected (cycle, value) results, a table-driven impulse
// test and hand sequences for clear, overrun and reset corner cases.
module tb_aud_fir_decim;

  localparam int BITS = 16;
  localparam int NT   = 32;
  localparam int DEC  = 2;
  localparam int LAT  = NT + 4;

  logic                   CLK = 1'b0;
  logic                   RSTb;
  logic                   in_tick;
  logic signed [BITS-1:0] x_in;
  logic signed [BITS-1:0] x_out;
  logic                   out_tick;
  logic                   busy;
  logic                   overrun;

  aud_fir_decim #(
    .BITS(BITS), .NTAPS(NT), .DECIM(DEC), .COEF_BITS(16), .ACC_WIDTH(40)
  ) dut (
    .CLK(CLK), .RSTb(RSTb), .in_tick(in_tick), .x_in(x_in),
    .x_out(x_out), .out_tick(out_tick), .busy(busy), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  typedef struct { int cyc; int val; } ev_t;
  typedef struct { int x; bit trig; int exp; } vec_t;

  int  HALF[16] = '{-20, -40, 30, 80, -50, -150, 70, 280,
                    -90, -480, 100, 850, -110, -1650, 120, 17444};
  int  C[NT];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  ev_t obs_q[$];
  ev_t exp_q[$];
  int  hist[$];
  int  m_phase;
  int  m_busy_until;
  int  m_clear_end;
  bit  m_overrun;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) if (out_tick) obs_q.push_back('{cyc, int'(x_out)});

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // y = sat(round(sum_k x[n-k]*c[k] / 2^15)), newest sample with c[0]
  function automatic int ref_out();
    longint acc = 0;
    for (int k = 0; k < NT; k++) acc += longint'(hist[NT-1-k]) * longint'(C[k]);
    return sat16((acc + 16384) >>> 15);
  endfunction

  task automatic model_reset(input int release_cyc);
    hist.delete();
    for (int i = 0; i < NT; i++) hist.push_back(0);
    m_phase      = 0;
    m_busy_until = -1000;
    m_clear_end  = release_cyc + NT;
    m_overrun    = 0;
    exp_q.delete();
  endtask

  task automatic model_tick(input int x, input int t0);
    if (t0 < m_clear_end) return;
    hist.push_back(x);
    void'(hist.pop_front());
    if (m_phase == DEC - 1) begin
      m_phase = 0;
      if (t0 < m_busy_until) m_overrun = 1;
      else begin
        exp_q.push_back('{t0 + LAT, ref_out()});
        m_busy_until = t0 + LAT;
      end
    end else m_phase++;
  endtask

  // One input sample in the current cycle, then idle until gap cycles have passed.
  task automatic send(input int x, input int gap);
    int t0;
    t0 = cyc;
    in_tick = 1'b1;
    x_in = BITS'(x);
    model_tick(x, t0);
    @(posedge CLK); #1;
    in_tick = 1'b0;
    repeat (gap - 1) begin @(posedge CLK); #1; end
  endtask

  task automatic assert_reset();
    RSTb = 1'b0;
    in_tick = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end
  endtask

  // Release reset and count cycles with busy high over a fixed window.
  task automatic release_and_count(input bit inject, output int n);
    n = 0;
    RSTb = 1'b1;
    model_reset(cyc);
    for (int i = 0; i < 40; i++) begin
      in_tick = inject && (i % 5 == 2) && (i < 30);
      x_in = BITS'(5000 + i);
      if (in_tick) model_tick(5000 + i, cyc);
      @(negedge CLK);
      if (busy) n++;
      @(posedge CLK); #1;
    end
    in_tick = 1'b0;
  endtask

  task automatic drain_check(input string name);
    ev_t e;
    ev_t o;
    repeat (LAT + 4) begin @(posedge CLK); #1; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_missing actual=none required=%0d", name, e.val);
      end else begin
        o = obs_q.pop_front();
        chk({name, "_cycle"}, o.cyc, e.cyc);
        chk({name, "_value"}, o.val, e.val);
      end
    end
    chk({name, "_extra_outputs"}, obs_q.size(), 0);
    obs_q.delete();
  endtask

  function automatic int last_obs();
    if (obs_q.size() == 0) return 999999;
    return obs_q[$].val;
  endfunction

  initial begin
    vec_t tbl[40];
    int   n;
    int   j;

    for (int k = 0; k < NT; k++) C[k] = (k < 16) ? HALF[k] : HALF[NT-1-k];
    for (int i = 0; i < 40; i++) begin
      tbl[i].x    = (i == 0) ? 16384 : 0;
      tbl[i].trig = (i % 2 == 1);
      tbl[i].exp  = (i < NT) ? int'((longint'(C[i]) * 16384 + 16384) >>> 15) : 0;
    end

    // Reset values and clear sequence with ignored inputs
    RSTb = 1'b0; in_tick = 1'b0; x_in = '0;
    repeat (3) begin @(posedge CLK); #1; end
    chk("rst_x_out", int'(x_out), 0);
    chk("rst_out_tick", int'(out_tick), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_busy", int'(busy), 1);
    release_and_count(1'b1, n);
    chk("clear_busy_cycles", n, NT);
    chk("clear_no_out_tick", obs_q.size(), 0);
    chk("clear_no_overrun", int'(overrun), 0);
    send(20000, 12);
    send(-30000, 45);
    drain_check("first_after_clear");

    // DC gain
    assert_reset();
    release_and_count(1'b0, n);
    for (int i = 0; i < 40; i++) send(1000, 64);
    chk("dc_final_value", last_obs(), 1000);
    chk("dc_output_count", obs_q.size(), 20);
    drain_check("dc");

    // Impulse response, table driven
    assert_reset();
    release_and_count(1'b0, n);
    for (int i = 0; i < 40; i++) send(tbl[i].x, 40);
    j = 0;
    for (int i = 0; i < 40; i++) begin
      if (tbl[i].trig) begin
        if (j < obs_q.size()) chk($sformatf("impulse_tap%0d", i), obs_q[j].val, tbl[i].exp);
        else chk($sformatf("impulse_tap%0d_present", i), 0, 1);
        j++;
      end
    end
    drain_check("impulse");

    // Positive saturation
    assert_reset();
    release_and_count(1'b0, n);
    for (int i = 1; i <= NT; i++) send((C[NT-i] >= 0) ? 32767 : -32768, 40);
    chk("sat_pos", last_obs(), 32767);
    drain_check("sat_pos_model");

    // Negative saturation
    assert_reset();
    release_and_count(1'b0, n);
    for (int i = 1; i <= NT; i++) send((C[NT-i] >= 0) ? -32768 : 32767, 40);
    chk("sat_neg", last_obs(), -32768);
    drain_check("sat_neg_model");

    // Overrun: triggers 20 cycles apart, then a normal one; flag stays set
    assert_reset();
    release_and_count(1'b0, n);
    send(300, 10);
    send(-700, 10);
    send(0, 10);
    send(0, 60);
    chk("overrun_set", int'(overrun), 1);
    chk("overrun_model", int'(overrun), int'(m_overrun));
    send(4000, 40);
    send(-5000, 45);
    chk("overrun_sticky", int'(overrun), 1);
    drain_check("overrun");
    assert_reset();
    chk("overrun_cleared_by_reset", int'(overrun), 0);

    // Reset in the middle of a MAC
    release_and_count(1'b0, n);
    send(500, 12);
    send(600, 1);
    repeat (9) begin @(posedge CLK); #1; end
    RSTb = 1'b0;
    #1;
    chk("midmac_busy", int'(busy), 1);
    chk("midmac_x_out", int'(x_out), 0);
    repeat (3) begin @(posedge CLK); #1; end
    release_and_count(1'b0, n);
    chk("midmac_clear_cycles", n, NT);
    chk("midmac_no_out_tick", obs_q.size(), 0);
    chk("midmac_x_out_after", int'(x_out), 0);
    exp_q.delete();

    // Randomised samples and spacing against the model
    for (int i = 0; i < 60; i++) send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(36, 50)));
    drain_check("random");
    chk("random_no_overrun", int'(overrun), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aud_fir_decim.md
Name: aud_fir_decim

Overview:
- Compensating FIR decimator placed directly downstream of the audio CIC decimator.
- Consumes the CIC output samples and their one-cycle ticks, corrects the CIC passband droop, and decimates by DECIM.
- Uses a single time-multiplexed multiply-accumulate (MAC) over a circular sample buffer.
- Output feeds the audio sink path at the final audio rate.

Parameters:
- BITS, 16: input/output sample width, signed.
- NTAPS, 32: number of FIR taps; power of two, ≥ 8.
- DECIM, 2: decimation factor, ≥ 1.
- COEF_BITS, 16: coefficient width, signed Q1.15.
- ACC_WIDTH, 40: accumulator width, signed.

Ports:
- CLK  in  1  system clock
- RSTb  in  1  asynchronous active-low reset
- in_tick  in  1  one-cycle strobe; x_in valid (driven from the CIC out_tick)
- x_in  in  BITS  signed input sample
- x_out  out  BITS  signed filtered, decimated sample; held between ticks
- out_tick  out  1  one-cycle strobe when x_out is updated
- busy  out  1  high during CLEAR or MAC activity
- overrun  out  1  sticky; a computation trigger arrived while busy

Behaviour:
- Interface: single clock CLK; reset RSTb is asynchronous, active-low.
- Reset values:
  - x_out=0, out_tick=0, overrun=0, busy=1.
  - Write pointer wp=0, phase=0, accumulator=0.
  - FSM=CLEAR.
- CLEAR:
  - Writes zero to buffer[0..NTAPS-1], one entry per cycle, over NTAPS cycles, then goes to IDLE (busy=0).
  - in_tick is ignored in CLEAR: no write, no phase count, no overrun.
- Sample write, any non-CLEAR state:
  - On in_tick: buffer[wp] <= x_in, then wp <= wp+1 modulo NTAPS (wraps NTAPS-1 -> 0).
  - On the same in_tick: phase <= phase+1, wrapping DECIM-1 -> 0.
  - Trigger condition: in_tick with phase==DECIM-1.
- Trigger in IDLE (trigger cycle = cycle 0):
  - Latch base = wp+1 (index of the sample just written, plus one); clear the accumulator; go to MAC.
- MAC, cycles 1..NTAPS, k = 0..NTAPS-1:
  - Read buffer[(base-1-k) mod NTAPS] and coef[k]; the newest sample pairs with coef[0].
  - Pipeline: registered read, then registered signed product (BITS+COEF_BITS), then accumulate (sign-extended to ACC_WIDTH).
  - The last product is accumulated at the end of cycle NTAPS+2.
- ROUND, cycle NTAPS+3:
  - r = (acc + 2^14) >>> 15, arithmetic shift, round half up.
  - Saturate r to [-2^(BITS-1), 2^(BITS-1)-1].
  - Register the result into x_out and pulse out_tick.
- Latency: out_tick is high in exactly cycle NTAPS+4 after the triggering in_tick. FSM then returns to IDLE, so busy is low from cycle NTAPS+4.
- Trigger while busy (MAC/ROUND):
  - The sample is still written and phase still advances.
  - The trigger is dropped (no second computation) and overrun <= 1.
  - The current computation finishes unaffected, because reads use the latched base.
  - Required input spacing for loss-free operation: ≥ NTAPS+4 cycles between triggers.
- Samples written during MAC may overwrite the oldest buffer entries. This is legal only under the spacing rule; otherwise overrun is flagged.
- Reset mid-operation: an immediate asynchronous return to the reset values; the computation in flight is discarded and CLEAR is re-run.
- out_tick never asserts during CLEAR.
- DECIM=1: every in_tick is a trigger.
- Coefficients: symmetric, inverse-sinc compensated low-pass; sum of coef = 32768 (unity DC gain).

Decomposition:
- Shared package aud_pkg:
  - NTAPS, COEF_BITS and ACC_WIDTH defaults.
  - Q-format shift constant COEF_FRAC=15.
  - FSM state encoding: CLEAR, IDLE, MAC, ROUND.
  - Saturation helper function.
- Sub-module aud_fir_coef_rom: synchronous-read coefficient table indexed by k. It has a one-cycle latency that matches the buffer read, which keeps the product stage aligned.

Test Plan:
- Post-reset: RSTb low 3 cycles, then high -> busy=1 for exactly 32 cycles. in_tick pulses during CLEAR produce no out_tick. First trigger after CLEAR yields x_out computed from zeros plus the new samples only.
- DC: x_in=1000 on every tick, ticks 64 cycles apart, 40 ticks -> after 32 inputs the output is constant x_out=1000. out_tick appears every 2nd input, 36 cycles after the trigger tick.
- Impulse: single x_in=16384 then zeros -> successive outputs equal round(c[k]/2) for k = 1, 3, 5, …, given the impulse lands at phase 0. Verifies coefficient ordering and wp wrap.
- Saturation: inputs set to +32767 where the matching coef is ≥ 0 and -32768 where it is < 0, over 32 taps -> x_out=32767. Sign-inverted pattern -> x_out=-32768. No wrap-around.
- Overrun: triggers 20 cycles apart -> second trigger dropped, overrun=1 and sticky. The first result still appears at cycle 36. Only RSTb clears overrun.
- Reset mid-MAC: RSTb low at cycle 10 of a MAC -> no out_tick, x_out=0, and CLEAR runs again.
